// File: rtl/mst_pref_buf.sv
// mst_pref_buf: parametrised multi-channel prefetch buffer for the FT60x
// master FIFO bridge. Each channel owns a DEPTH-word circular buffer that is
// filled from either the internal channel FIFO (loop-back) or a streaming
// pattern generator, and is drained show-ahead by the bus write engine.
// Fill and drain use independent channel selects.
// Fills run through a one-stage request pipeline: request in cycle t, data
// returns and is written in cycle t+1.
// Optional feature: define MST_PREF_ERR_EN to build the sticky per-channel
// underflow flags on pref_err; when it is undefined, pref_err is tied to zero.
module mst_pref_buf #(
  parameter int NCH     = 4,
  parameter int CHBIT   = 2,
  parameter int WIDTH   = 36,
  parameter int DEPTH   = 4,
  parameter int ADDRBIT = 2,
  parameter int GENW    = WIDTH - 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pref_ena,
  input  logic [NCH-1:0]      pref_mod,
  input  logic [CHBIT-1:0]    fill_chn,
  input  logic [NCH-1:0]      pref_flush,
  input  logic                rd_req,
  input  logic [CHBIT-1:0]    rd_chn,
  output logic [WIDTH-1:0]    rd_dout,
  output logic [NCH-1:0]      pref_nempt,
  output logic [NCH-1:0]      pref_full,
  output logic                ififo_rd,
  input  logic [NCH-1:0]      ifnempt,
  input  logic [WIDTH-1:0]    ififodat,
  output logic [NCH-1:0]      gen_req,
  input  logic [NCH*GENW-1:0] gen_dat,
  output logic [NCH-1:0]      pref_err
);

  localparam int LENW = ADDRBIT + 1;
  localparam int PADW = WIDTH - GENW;
  localparam logic [LENW:0]   DEPTH_CMP  = (LENW+1)'(DEPTH);
  localparam logic [LENW-1:0] DEPTH_LEN  = LENW'(DEPTH);

  // Per-channel pointer and occupancy views, gathered for the channel muxes
  logic [ADDRBIT-1:0] wrptr_all [NCH];
  logic [ADDRBIT-1:0] rdptr_all [NCH];
  logic [LENW-1:0]    len_all   [NCH];

  // One-stage fill request pipeline
  logic               req_p1_reg;
  logic [CHBIT-1:0]   chn_p1_reg;
  logic               mod_p1_reg;

  // Fill issue
  logic               fill_ok;
  logic               inflight;
  logic [LENW:0]      fill_level;
  logic               fill_req;

  // Write side
  logic               wr_en;
  logic [GENW-1:0]    gen_sel;
  logic [WIDTH-1:0]   wr_data;

  // Read side
  logic               rd_ok;
  logic               rd_hit;
  logic               pop;

  // Shared storage for all channels, addressed {channel, pointer}. Read is
  // asynchronous because the write engine needs the head word with zero
  // latency, so this maps to distributed RAM rather than block RAM.
  logic [WIDTH-1:0]   mem [NCH*DEPTH];

  // Fill throttle: a word already requested for this channel but not yet
  // written counts toward the fill level, so the buffer can use all DEPTH
  // slots without ever overflowing.
  always_comb begin
    fill_ok    = (32'(fill_chn) < NCH);
    inflight   = req_p1_reg & (chn_p1_reg == fill_chn);
    fill_level = {1'b0, len_all[fill_chn]} + {{LENW{1'b0}}, inflight};
    fill_req   = ~rst & pref_ena & fill_ok & ~pref_flush[fill_chn]
               & (fill_level < DEPTH_CMP)
               & (pref_mod[fill_chn] | ifnempt[fill_chn]);
  end

  assign ififo_rd = fill_req & ~pref_mod[fill_chn];

  // Generator request is one-hot on the channel being filled in streaming mode
  always_comb begin
    gen_req = '0;
    if (fill_req & pref_mod[fill_chn]) begin
      gen_req[fill_chn] = 1'b1;
    end
  end

  // Capture the issued request; the mode is frozen here so a later mode
  // change cannot redirect a word that is already on its way.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_p1_reg <= 1'b0;
      chn_p1_reg <= '0;
      mod_p1_reg <= 1'b0;
    end else begin
      req_p1_reg <= fill_req;
      chn_p1_reg <= fill_chn;
      mod_p1_reg <= pref_mod[fill_chn];
    end
  end

  // Returned data: generator words are padded with all byte enables set.
  // A flush of the destination channel in the return cycle drops the word.
  assign gen_sel = gen_dat[chn_p1_reg*GENW +: GENW];
  assign wr_data = mod_p1_reg ? {{PADW{1'b1}}, gen_sel} : ififodat;
  assign wr_en   = ~rst & req_p1_reg & ~pref_flush[chn_p1_reg];

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{chn_p1_reg, wrptr_all[chn_p1_reg]}] <= wr_data;
    end
  end

  // Show-ahead read of the selected channel; empty channels read as zero
  // and a request against an empty channel is ignored.
  always_comb begin
    rd_ok   = (32'(rd_chn) < NCH);
    rd_hit  = rd_ok & pref_nempt[rd_chn];
    pop     = rd_req & rd_hit;
    rd_dout = rd_hit ? mem[{rd_chn, rdptr_all[rd_chn]}] : '0;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chn
    logic [ADDRBIT-1:0] wrptr_reg;
    logic [ADDRBIT-1:0] rdptr_reg;
    logic [LENW-1:0]    len_reg;
    logic [LENW-1:0]    len_next;
    logic               wr_hit;
    logic               pop_hit;

    assign wr_hit  = wr_en & (chn_p1_reg == CHBIT'(gi));
    assign pop_hit = pop & (rd_chn == CHBIT'(gi));

    // Occupancy: a same-cycle write and pop cancel, at any fill level
    always_comb begin
      len_next = len_reg;
      if (wr_hit && !pop_hit) begin
        len_next = len_reg + LENW'(1);
      end else if (pop_hit && !wr_hit) begin
        len_next = len_reg - LENW'(1);
      end
    end

    // Pointer and occupancy registers; flush outranks any same-cycle write or pop
    always_ff @(posedge clk) begin
      if (rst || pref_flush[gi]) begin
        wrptr_reg <= '0;
        rdptr_reg <= '0;
        len_reg   <= '0;
      end else begin
        if (wr_hit) begin
          wrptr_reg <= wrptr_reg + ADDRBIT'(1);
        end
        if (pop_hit) begin
          rdptr_reg <= rdptr_reg + ADDRBIT'(1);
        end
        len_reg <= len_next;
      end
    end

    assign wrptr_all[gi]  = wrptr_reg;
    assign rdptr_all[gi]  = rdptr_reg;
    assign len_all[gi]    = len_reg;
    assign pref_nempt[gi] = (len_reg != '0);
    assign pref_full[gi]  = (len_reg == DEPTH_LEN);

`ifdef MST_PREF_ERR_EN
    logic err_reg;

    // Sticky underflow flag: a read request against this channel while empty
    always_ff @(posedge clk) begin
      if (rst || pref_flush[gi]) begin
        err_reg <= 1'b0;
      end else if (rd_req && (rd_chn == CHBIT'(gi)) && (len_reg == '0)) begin
        err_reg <= 1'b1;
      end
    end

    assign pref_err[gi] = err_reg;
`else
    assign pref_err[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mst_pref_buf.sv
// Self-checking bench for mst_pref_buf: directed scenarios followed by a
// randomized run, all compared against a queue-based channel model.
module tb_mst_pref_buf;

  localparam int NCH     = 4;
  localparam int CHBIT   = 2;
  localparam int WIDTH   = 36;
  localparam int DEPTH   = 4;
  localparam int ADDRBIT = 2;
  localparam int GENW    = WIDTH - 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                pref_ena;
  logic [NCH-1:0]      pref_mod;
  logic [CHBIT-1:0]    fill_chn;
  logic [NCH-1:0]      pref_flush;
  logic                rd_req;
  logic [CHBIT-1:0]    rd_chn;
  logic [WIDTH-1:0]    rd_dout;
  logic [NCH-1:0]      pref_nempt;
  logic [NCH-1:0]      pref_full;
  logic                ififo_rd;
  logic [NCH-1:0]      ifnempt;
  logic [WIDTH-1:0]    ififodat;
  logic [NCH-1:0]      gen_req;
  logic [NCH*GENW-1:0] gen_dat;
  logic [NCH-1:0]      pref_err;

  always #5 clk = ~clk;

  mst_pref_buf #(
    .NCH(NCH), .CHBIT(CHBIT), .WIDTH(WIDTH),
    .DEPTH(DEPTH), .ADDRBIT(ADDRBIT), .GENW(GENW)
  ) dut (
    .clk(clk), .rst(rst), .pref_ena(pref_ena), .pref_mod(pref_mod),
    .fill_chn(fill_chn), .pref_flush(pref_flush), .rd_req(rd_req),
    .rd_chn(rd_chn), .rd_dout(rd_dout), .pref_nempt(pref_nempt),
    .pref_full(pref_full), .ififo_rd(ififo_rd), .ifnempt(ifnempt),
    .ififodat(ififodat), .gen_req(gen_req), .gen_dat(gen_dat),
    .pref_err(pref_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a plain FIFO of words
  logic [WIDTH-1:0] mq [NCH][$];
  logic [WIDTH-1:0] fifo_cnt [NCH];
  logic [GENW-1:0]  gen_cnt [NCH];
  logic             pend_v;
  int               pend_ch;
  logic             pend_mod;
  logic [WIDTH-1:0] pend_word;
  logic [NCH-1:0]   m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: present returned data, check all outputs, advance the model
  task automatic cycle();
    int               fc;
    int               rc;
    logic             inf;
    logic             ereq;
    logic [NCH-1:0]   egen;
    logic [NCH-1:0]   enempt;
    logic [NCH-1:0]   efull;
    logic [WIDTH-1:0] edout;
    logic [WIDTH-1:0] w;

    ififodat = {4'($urandom), $urandom};
    gen_dat  = {$urandom, $urandom, $urandom, $urandom};
    if (pend_v) begin
      if (pend_mod) gen_dat[pend_ch*GENW +: GENW] = pend_word[GENW-1:0];
      else          ififodat = pend_word;
    end
    #1;

    fc   = int'(fill_chn);
    rc   = int'(rd_chn);
    inf  = pend_v && (pend_ch == fc);
    ereq = !rst && pref_ena && !pref_flush[fc] &&
           ((mq[fc].size() + int'(inf)) < DEPTH) &&
           (pref_mod[fc] || ifnempt[fc]);
    egen = '0;
    if (ereq && pref_mod[fc]) egen[fc] = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      enempt[c] = (mq[c].size() > 0);
      efull[c]  = (mq[c].size() == DEPTH);
    end
    edout = (mq[rc].size() > 0) ? mq[rc][0] : '0;

    chk("ififo_rd",   64'(ififo_rd),   64'(ereq && !pref_mod[fc]));
    chk("gen_req",    64'(gen_req),    64'(egen));
    chk("rd_dout",    64'(rd_dout),    64'(edout));
    chk("pref_nempt", 64'(pref_nempt), 64'(enempt));
    chk("pref_full",  64'(pref_full),  64'(efull));
    chk("pref_err",   64'(pref_err),   64'(m_err));

    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_err  = '0;
      pend_v = 1'b0;
    end else begin
      if (rd_req) begin
        if (mq[rc].size() > 0) begin
          if (!pref_flush[rc]) begin
            w = mq[rc].pop_front();
            $display("pop ch%0d data %09h", rc, w);
          end
        end else begin
`ifdef MST_PREF_ERR_EN
          m_err[rc] = 1'b1;
`endif
        end
      end
      if (pend_v && !pref_flush[pend_ch]) mq[pend_ch].push_back(pend_word);
      for (int c = 0; c < NCH; c++) begin
        if (pref_flush[c]) begin
          mq[c].delete();
          m_err[c] = 1'b0;
        end
      end
      pend_v = ereq;
      if (ereq) begin
        pend_ch  = fc;
        pend_mod = pref_mod[fc];
        if (pref_mod[fc]) begin
          pend_word = {4'hF, gen_cnt[fc]};
          gen_cnt[fc] = gen_cnt[fc] + 1;
        end else begin
          pend_word = fifo_cnt[fc];
          fifo_cnt[fc] = fifo_cnt[fc] + 1;
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic exp_uf;

    rst = 1'b1; pref_ena = 1'b0; pref_mod = '0; fill_chn = '0;
    pref_flush = '0; rd_req = 1'b0; rd_chn = '0; ifnempt = '0;
    ififodat = '0; gen_dat = '0;
    pend_v = 1'b0; pend_ch = 0; pend_mod = 1'b0; pend_word = '0; m_err = '0;
    for (int c = 0; c < NCH; c++) begin
      fifo_cnt[c] = '0;
      gen_cnt[c]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_nempt", 64'(pref_nempt), 64'(0));
    chk("reset_full",  64'(pref_full),  64'(0));
    chk("reset_dout",  64'(rd_dout),    64'(0));
    chk("reset_err",   64'(pref_err),   64'(0));
    cycle();
    rst = 1'b0;

    // Loop-back fill of ch1: exactly DEPTH reads, then in-order pops
    fifo_cnt[1] = 36'hA;
    pref_ena = 1'b1; fill_chn = 2'd1; ifnempt = 4'b0010;
    n = 0;
    repeat (8) begin
      #1;
      if (ififo_rd === 1'b1) n++;
      cycle();
    end
    chk("lb_reads", 64'(n), 64'(4));
    chk("lb_full1", 64'(pref_full[1]), 64'(1));
    pref_ena = 1'b0; rd_chn = 2'd1;
    #1;
    chk("lb_head", 64'(rd_dout), 64'(36'hA));
    rd_req = 1'b1;
    repeat (4) cycle();
    rd_req = 1'b0;
    #1;
    chk("lb_drained", 64'(pref_nempt[1]), 64'(0));

    // Streaming fill of ch2
    gen_cnt[2] = 32'h100;
    pref_mod = 4'b0100; fill_chn = 2'd2; pref_ena = 1'b1;
    #1;
    chk("st_genreq", 64'(gen_req), 64'(4'b0100));
    repeat (6) cycle();
    pref_ena = 1'b0;
    cycle();
    chk("st_full2", 64'(pref_full[2]), 64'(1));
    rd_chn = 2'd2;
    #1;
    chk("st_head", 64'(rd_dout), 64'(36'hF00000100));
    rd_req = 1'b1;
    repeat (4) cycle();
    rd_req = 1'b0;

    // Simultaneous fill and drain of ch0 at len 2, across pointer wrap
    pref_mod = '0; fill_chn = 2'd0; ifnempt = 4'b0001; fifo_cnt[0] = 36'h100;
    rd_chn = 2'd0; pref_ena = 1'b1;
    cycle(); cycle();
    pref_ena = 1'b0;
    cycle();
    pref_ena = 1'b1;
    cycle();
    rd_req = 1'b1;
    repeat (14) cycle();
    #1;
    chk("fd_nempt0", 64'(pref_nempt[0]), 64'(1));
    chk("fd_full0",  64'(pref_full[0]),  64'(0));
    pref_ena = 1'b0;
    repeat (3) cycle();
    rd_req = 1'b0;
    #1;
    chk("fd_drained", 64'(pref_nempt[0]), 64'(0));

    // Cross-channel switch with a ch3 word in flight
    fifo_cnt[3] = 36'h300; fifo_cnt[0] = 36'h200;
    ifnempt = 4'b1001; fill_chn = 2'd3; pref_ena = 1'b1;
    cycle();
    fill_chn = 2'd0;
    #1;
    chk("xc_switch_req", 64'(ififo_rd), 64'(1));
    cycle();
    pref_ena = 1'b0;
    cycle();
    #1;
    chk("xc_ch3_nempt", 64'(pref_nempt[3]), 64'(1));
    chk("xc_ch0_nempt", 64'(pref_nempt[0]), 64'(1));

    // Flush of ch1 colliding with its in-flight write
    fifo_cnt[1] = 36'h1A0; ifnempt = 4'b1011; fill_chn = 2'd1; pref_ena = 1'b1;
    cycle();
    pref_ena = 1'b0; pref_flush = 4'b0010;
    cycle();
    pref_flush = '0; rd_chn = 2'd0;
    #1;
    chk("fl_nempt1", 64'(pref_nempt[1]), 64'(0));
    chk("fl_ch0_head", 64'(rd_dout), 64'(36'h200));
    rd_req = 1'b1;
    cycle();
    rd_req = 1'b0;

    // Underflow on ch3
`ifdef MST_PREF_ERR_EN
    exp_uf = 1'b1;
`else
    exp_uf = 1'b0;
`endif
    rd_chn = 2'd3; rd_req = 1'b1;
    cycle();
    cycle();
    rd_req = 1'b0;
    #1;
    chk("uf_dout",  64'(rd_dout),        64'(0));
    chk("uf_nempt", 64'(pref_nempt[3]),  64'(0));
    chk("uf_err",   64'(pref_err[3]),    64'(exp_uf));
    cycle();
    pref_flush = 4'b1000;
    cycle();
    pref_flush = '0;
    #1;
    chk("uf_err_clr", 64'(pref_err[3]), 64'(0));

    // Reset mid-fill drops the in-flight word
    pref_mod = 4'b0100; fill_chn = 2'd2; pref_ena = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; pref_ena = 1'b0;
    cycle();
    #1;
    chk("rst_nowrite", 64'(pref_nempt), 64'(0));

    // Randomized traffic
    repeat (800) begin
      rst        = ($urandom_range(0, 99) == 0);
      pref_ena   = ($urandom_range(0, 3) != 0);
      pref_mod   = 4'($urandom);
      fill_chn   = 2'($urandom);
      pref_flush = ($urandom_range(0, 15) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      rd_req     = 1'($urandom_range(0, 1));
      rd_chn     = 2'($urandom);
      ifnempt    = 4'($urandom);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
